// File: rtl/sram_arbiter_if.sv
// Requester-side handshake bundle for the SRAM arbiter.
// The logger port is write-only. The SPI-host port can read or write.
interface sram_arbiter_if;
  logic        log_req;
  logic [16:0] log_addr;
  logic [7:0]  log_data;
  logic        log_ack;
  logic        host_req;
  logic        host_we;
  logic [16:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_ack;
  logic [7:0]  host_rdata;

  modport master (
    output log_req, log_addr, log_data, host_req, host_we, host_addr, host_wdata,
    input  log_ack, host_ack, host_rdata
  );

  modport slave (
    input  log_req, log_addr, log_data, host_req, host_we, host_addr, host_wdata,
    output log_ack, host_ack, host_rdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter (logger and SPI host) in front of an asynchronous SRAM.
// It uses round-robin grants and generates fixed-width strobe timing.
//
// state  | meaning
// IDLE   | enables inactive, bus released, requests sampled here only
// SETUP  | address and chip enable presented; data driven on writes
// WPULSE | wen low for WR_CYCLES cycles
// WHOLD  | wen released, data still driven, ack to the granted port
// RWAIT  | oen low for RD_CYCLES cycles, read data captured at the end
// RLATCH | oen released, ack to the host
module sram_arbiter #(
  parameter int WR_CYCLES = 2,
  parameter int RD_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rstn,
  sram_arbiter_if.slave bus,
  output logic         busy,
  output logic [16:0]  addr,
  inout  wire  [7:0]   data,
  output logic         cen,
  output logic         oen,
  output logic         wen
);

  typedef enum logic [2:0] {IDLE, SETUP, WPULSE, WHOLD, RWAIT, RLATCH} state_t;

  state_t      state, state_nx;
  logic        armed;
  logic        last_host;
  logic        cur_host;
  logic        cur_we;
  logic [16:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;
  logic [3:0]  cnt;
  logic        grant;
  logic        grant_host;
  logic        data_oe;
  logic        cnt_last;

  always_comb begin
    state_nx   = state;
    grant      = 1'b0;
    grant_host = 1'b0;
    cen        = 1'b1;
    oen        = 1'b1;
    wen        = 1'b1;
    data_oe    = 1'b0;
    cnt_last   = (cnt == 4'd1);
    case (state)
      IDLE: begin
        // armed holds off the first grant until the second edge after reset release
        if (armed && (bus.log_req || bus.host_req)) begin
          grant      = 1'b1;
          grant_host = bus.host_req && (!bus.log_req || !last_host);
          state_nx   = SETUP;
        end
      end
      SETUP: begin
        cen      = 1'b0;
        oen      = cur_we;
        data_oe  = cur_we;
        state_nx = cur_we ? WPULSE : RWAIT;
      end
      WPULSE: begin
        cen     = 1'b0;
        wen     = 1'b0;
        data_oe = 1'b1;
        if (cnt_last) state_nx = WHOLD;
      end
      WHOLD: begin
        cen      = 1'b0;
        data_oe  = 1'b1;
        state_nx = IDLE;
      end
      RWAIT: begin
        cen = 1'b0;
        oen = 1'b0;
        if (cnt_last) state_nx = RLATCH;
      end
      RLATCH: begin
        cen      = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      armed     <= 1'b0;
      last_host <= 1'b1;
      cur_host  <= 1'b0;
      cur_we    <= 1'b0;
      addr_q    <= 17'd0;
      wdata_q   <= 8'd0;
      rdata_q   <= 8'd0;
      cnt       <= 4'd0;
    end else begin
      state <= state_nx;
      armed <= 1'b1;
      if (grant) begin
        last_host <= grant_host;
        cur_host  <= grant_host;
        cur_we    <= grant_host ? bus.host_we : 1'b1;
        addr_q    <= grant_host ? bus.host_addr : bus.log_addr;
        wdata_q   <= grant_host ? bus.host_wdata : bus.log_data;
      end
      case (state)
        SETUP:         cnt <= cur_we ? 4'(WR_CYCLES) : 4'(RD_CYCLES);
        WPULSE, RWAIT: if (!cnt_last) cnt <= cnt - 4'd1;
        default:       ;
      endcase
      if (state == RWAIT && cnt_last) rdata_q <= data;
    end
  end

  assign data           = data_oe ? wdata_q : 8'hzz;
  assign busy           = (state != IDLE);
  assign addr           = addr_q;
  assign bus.host_rdata = rdata_q;
  assign bus.log_ack    = (state == WHOLD) && !cur_host;
  assign bus.host_ack   = ((state == WHOLD) || (state == RLATCH)) && cur_host;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter. It runs a default-timing instance and a WR=1/RD=15 instance.
// Each instance has its own behavioural SRAM and is checked for strobe protocol on every cycle.
module tb_sram_arbiter;
  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  logic        log_req = 1'b0, host_req = 1'b0, host_we = 1'b0;
  logic [16:0] log_addr = '0, host_addr = '0;
  logic [7:0]  log_data = '0, host_wdata = '0;
  logic        sel = 1'b0;
  int          checks = 0;
  int          failures = 0;

  sram_arbiter_if bus1();
  sram_arbiter_if bus2();
  assign bus1.log_req = log_req;   assign bus2.log_req = log_req;
  assign bus1.log_addr = log_addr; assign bus2.log_addr = log_addr;
  assign bus1.log_data = log_data; assign bus2.log_data = log_data;
  assign bus1.host_req = host_req; assign bus2.host_req = host_req;
  assign bus1.host_we = host_we;   assign bus2.host_we = host_we;
  assign bus1.host_addr = host_addr;   assign bus2.host_addr = host_addr;
  assign bus1.host_wdata = host_wdata; assign bus2.host_wdata = host_wdata;

  logic        busy1, cen1, oen1, wen1, busy2, cen2, oen2, wen2;
  logic [16:0] addr1, addr2;
  wire  [7:0]  data1, data2;

  sram_arbiter dut1 (.clk(clk), .rstn(rstn), .bus(bus1), .busy(busy1), .addr(addr1),
                     .data(data1), .cen(cen1), .oen(oen1), .wen(wen1));
  sram_arbiter #(.WR_CYCLES(1), .RD_CYCLES(15)) dut2 (.clk(clk), .rstn(rstn), .bus(bus2),
                     .busy(busy2), .addr(addr2), .data(data2), .cen(cen2), .oen(oen2), .wen(wen2));

  logic [7:0] mem1 [0:131071];
  logic [7:0] mem2 [0:131071];
  logic [7:0] rd1, rd2;
  always_comb rd1 = mem1[addr1];
  always_comb rd2 = mem2[addr2];
  assign data1 = (!cen1 && !oen1) ? rd1 : 8'hzz;
  assign data2 = (!cen2 && !oen2) ? rd2 : 8'hzz;
  always @(posedge clk) begin
    if (!cen1 && !wen1) mem1[addr1] <= data1;
    if (!cen2 && !wen2) mem2[addr2] <= data2;
  end

  wire       busy_s  = sel ? busy2 : busy1;
  wire       wen_s   = sel ? wen2 : wen1;
  wire       oen_s   = sel ? oen2 : oen1;
  wire       oe_s    = sel ? dut2.data_oe : dut1.data_oe;
  wire       lack_s  = sel ? bus2.log_ack : bus1.log_ack;
  wire       hack_s  = sel ? bus2.host_ack : bus1.host_ack;
  wire [7:0] hrd_s   = sel ? bus2.host_rdata : bus1.host_rdata;

  typedef struct {bit is_host; int lat; bit rd; logic [7:0] rdata;} exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    checks++;
    if ((!wen1 && !oen1) || (!wen2 && !oen2)) begin
      failures++; $display("FAIL proto_we_oe wen1=%b oen1=%b wen2=%b oen2=%b required not both low", wen1, oen1, wen2, oen2);
    end
    checks++;
    if ((!oen1 && dut1.data_oe) || (!oen2 && dut2.data_oe)) begin
      failures++; $display("FAIL proto_drive bus driven with oen low oe1=%b oe2=%b", dut1.data_oe, dut2.data_oe);
    end
    checks++;
    if ((!busy1 && !(cen1 && oen1 && wen1 && !dut1.data_oe)) || (!busy2 && !(cen2 && oen2 && wen2 && !dut2.data_oe))) begin
      failures++; $display("FAIL proto_idle cen/oen/wen=%b%b%b / %b%b%b required 111 while idle", cen1, oen1, wen1, cen2, oen2, wen2);
    end
    checks++;
    if ((bus1.log_ack && bus1.host_ack) || (bus2.log_ack && bus2.host_ack)) begin
      failures++; $display("FAIL proto_acks both acks high together");
    end
  end

  task automatic wait_ack(input int limit, input bit drop, output bit got, output bit is_host,
                          output int lat, output int idle, output int wen_lo, output int oen_lo,
                          output int drv, output logic [7:0] rdata);
    bit started = 0;
    got = 0; is_host = 0; lat = 0; idle = 0; wen_lo = 0; oen_lo = 0; drv = 0; rdata = '0;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge clk);
      if (!started && busy_s) started = 1;
      if (!started) idle++;
      else begin
        lat++;
        if (!wen_s) wen_lo++;
        if (!oen_s) oen_lo++;
        if (oe_s) drv++;
      end
      if (lack_s || hack_s) begin
        got = 1; is_host = hack_s; rdata = hrd_s;
        if (drop) begin
          if (hack_s) host_req = 0; else log_req = 0;
        end
      end
    end
  endtask

  task automatic reset_pulse;
    @(negedge clk); rstn = 0;
    repeat (2) @(negedge clk);
    rstn = 1;
  endtask

  task automatic test_reset;
    #1 rstn = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy1, cen1, oen1, wen1, bus1.log_ack, bus1.host_ack} !== 6'b011100 ||
        {busy2, cen2, oen2, wen2, bus2.log_ack, bus2.host_ack} !== 6'b011100) begin
      failures++; $display("FAIL reset_ctrl got %b/%b required 011100", {busy1, cen1, oen1, wen1, bus1.log_ack, bus1.host_ack},
                           {busy2, cen2, oen2, wen2, bus2.log_ack, bus2.host_ack});
    end
    checks++;
    if (addr1 !== 17'd0 || bus1.host_rdata !== 8'd0 || addr2 !== 17'd0 || bus2.host_rdata !== 8'd0) begin
      failures++; $display("FAIL reset_regs addr=%h rdata=%h required 0", addr1, bus1.host_rdata);
    end
  endtask

  task automatic test_host_write;
    bit got, ih; int lat, idle, wl, ol, drv; logic [7:0] rd; exp_t e;
    host_req = 1; host_we = 1; host_addr = 17'h139c6; host_wdata = 8'h9c;
    sb.push_back('{1, 4, 0, 8'h00});
    rstn = 1;
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b0) begin failures++; $display("FAIL first_grant_early busy=%b required 0", busy1); end
    wait_ack(20, 1, got, ih, lat, idle, wl, ol, drv, rd);
    e = sb.pop_front();
    checks++;
    if (!got) begin failures++; $display("FAIL wr_timeout no ack required ack"); end
    checks++;
    if (ih !== e.is_host || lat != e.lat || idle != 0) begin
      failures++; $display("FAIL wr_ack host=%b lat=%0d idle=%0d required host=%b lat=%0d idle=0", ih, lat, idle, e.is_host, e.lat);
    end
    checks++;
    if (wl != 2 || drv != 4) begin failures++; $display("FAIL wr_strobe wen_low=%0d drive=%0d required 2/4", wl, drv); end
    @(negedge clk);
    checks++;
    if (mem1[17'h139c6] !== 8'h9c) begin failures++; $display("FAIL wr_mem got %h required 9c", mem1[17'h139c6]); end
  endtask

  task automatic test_host_read;
    bit got, ih; int lat, idle, wl, ol, drv; logic [7:0] rd; exp_t e;
    host_req = 1; host_we = 0; host_addr = 17'h139c6; host_wdata = 8'h00;
    sb.push_back('{1, 4, 1, 8'h9c});
    wait_ack(20, 1, got, ih, lat, idle, wl, ol, drv, rd);
    e = sb.pop_front();
    checks++;
    if (!got || ih !== e.is_host || lat != e.lat) begin
      failures++; $display("FAIL rd_ack got=%b host=%b lat=%0d required 1/%b/%0d", got, ih, lat, e.is_host, e.lat);
    end
    checks++;
    if (ol != 3 || wl != 0 || drv != 0) begin
      failures++; $display("FAIL rd_strobe oen_low=%0d wen_low=%0d drive=%0d required 3/0/0", ol, wl, drv);
    end
    checks++;
    if (rd !== e.rdata) begin failures++; $display("FAIL rd_data got %h required %h", rd, e.rdata); end
  endtask

  task automatic test_back_to_back;
    bit got, ih; int lat, idle, wl, ol, drv; logic [7:0] rd; exp_t e;
    @(negedge clk);
    log_req = 1; log_addr = 17'h00300; log_data = 8'h5a;
    sb.push_back('{0, 4, 0, 8'h00});
    sb.push_back('{1, 4, 1, 8'h5a});
    @(posedge clk); #1;
    log_addr = 17'h00301; log_data = 8'hff;
    host_req = 1; host_we = 0; host_addr = 17'h00300;
    for (int k = 0; k < 2; k++) begin
      wait_ack(20, 1, got, ih, lat, idle, wl, ol, drv, rd);
      e = sb.pop_front();
      checks++;
      if (!got || ih !== e.is_host || lat != e.lat) begin
        failures++; $display("FAIL b2b_ack%0d got=%b host=%b lat=%0d required 1/%b/%0d", k, got, ih, lat, e.is_host, e.lat);
      end
      checks++;
      if (k == 0 && rd !== 8'h9c) begin failures++; $display("FAIL rdata_hold got %h required 9c", rd); end
      else if (k == 1 && (rd !== e.rdata || idle != 1)) begin
        failures++; $display("FAIL b2b_read data=%h idle=%0d required %h/1", rd, idle, e.rdata);
      end
    end
  endtask

  task automatic test_arbitration;
    bit got, ih; int lat, idle, wl, ol, drv; logic [7:0] rd; exp_t e;
    @(negedge clk); rstn = 0;
    log_req = 1; log_addr = 17'h00100; log_data = 8'h11;
    host_req = 1; host_we = 1; host_addr = 17'h00200; host_wdata = 8'h22;
    for (int k = 0; k < 4; k++) sb.push_back('{k[0], 4, 0, 8'h00});
    repeat (2) @(negedge clk);
    rstn = 1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(20, 0, got, ih, lat, idle, wl, ol, drv, rd);
      e = sb.pop_front();
      checks++;
      if (!got || ih !== e.is_host || lat != e.lat || (k > 0 && idle != 1)) begin
        failures++; $display("FAIL arb_grant%0d got=%b host=%b lat=%0d idle=%0d required host=%b lat=%0d", k, got, ih, lat, idle, e.is_host, e.lat);
      end
    end
    log_req = 0; host_req = 0;
  endtask

  task automatic test_reset_mid;
    bit got, ih; int lat, idle, wl, ol, drv; logic [7:0] rd; exp_t e; bit seen = 0;
    @(negedge clk);
    log_req = 1; log_addr = 17'h00400; log_data = 8'ha5;
    sb.push_back('{0, 4, 0, 8'h00});
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (!wen1) seen = 1;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL mid_wpulse never reached required wen low"); end
    #2 rstn = 0;
    #1;
    checks++;
    if ({cen1, oen1, wen1, busy1, bus1.log_ack} !== 5'b11100) begin
      failures++; $display("FAIL mid_abort cen/oen/wen/busy/ack=%b required 11100", {cen1, oen1, wen1, busy1, bus1.log_ack});
    end
    repeat (2) @(negedge clk);
    rstn = 1;
    wait_ack(20, 1, got, ih, lat, idle, wl, ol, drv, rd);
    e = sb.pop_front();
    checks++;
    if (!got || ih !== e.is_host || lat != e.lat || wl != 2) begin
      failures++; $display("FAIL mid_rerun got=%b host=%b lat=%0d wen_low=%0d required 1/0/4/2", got, ih, lat, wl);
    end
    @(negedge clk);
    checks++;
    if (mem1[17'h00400] !== 8'ha5) begin failures++; $display("FAIL mid_mem got %h required a5", mem1[17'h00400]); end
  endtask

  task automatic test_params;
    bit got, ih; int lat, idle, wl, ol, drv; logic [7:0] rd; exp_t e;
    sel = 1;
    host_req = 0; log_req = 0;
    reset_pulse();
    host_req = 1; host_we = 1; host_addr = 17'h00abc; host_wdata = 8'h3c;
    sb.push_back('{1, 3, 0, 8'h00});
    wait_ack(40, 1, got, ih, lat, idle, wl, ol, drv, rd);
    e = sb.pop_front();
    checks++;
    if (!got || lat != e.lat || wl != 1) begin
      failures++; $display("FAIL p_write got=%b lat=%0d wen_low=%0d required 1/%0d/1", got, lat, wl, e.lat);
    end
    host_req = 1; host_we = 0;
    sb.push_back('{1, 17, 1, 8'h3c});
    wait_ack(60, 1, got, ih, lat, idle, wl, ol, drv, rd);
    e = sb.pop_front();
    checks++;
    if (!got || lat != e.lat || ol != 16) begin
      failures++; $display("FAIL p_read got=%b lat=%0d oen_low=%0d required 1/%0d/16", got, lat, ol, e.lat);
    end
    checks++;
    if (rd !== e.rdata) begin failures++; $display("FAIL p_rdata got %h required %h", rd, e.rdata); end
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_host_write();
    test_host_read();
    test_back_to_back();
    test_arbitration();
    test_reset_mid();
    test_params();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
